nina_spi_byte_if: RTL
=====================

Name: nina_spi_byte_if

Overview:
- SPI-slave front end for the NINA ESP32 link. It oversamples the ESP32 SPI pins (MOSI, SCLK, CS) on the FPGA system clock and deserialises MOSI into a byte stream with a valid/ready handshake.
- It serialises response bytes onto MISO.
- It sits directly upstream of the SPI-to-Avalon bridge inside the system, replacing raw pin-level SPI with a byte interface.

Parameters:
- RX_DEPTH, 4, depth of the RX byte FIFO (power of 2, ≥2).
- FILL_BYTE, 8'hFF, byte shifted out on MISO when no TX byte is available.

Ports:
- iCLK  in  1  system clock; all logic in this domain.
- iRESET  in  1  synchronous reset, active-high.
- iSPI_SCLK  in  1  raw SPI clock from the ESP32, asynchronous.
- iSPI_MOSI  in  1  raw MOSI, asynchronous.
- iSPI_CSn  in  1  raw chip select, active-low, asynchronous.
- oSPI_MISO  out  1  MISO data.
- oSPI_MISO_OE  out  1  MISO output enable; high only while CS is synchronised-low.
- oRX_DATA  out  8  head of the RX FIFO.
- oRX_SOF  out  1  high when oRX_DATA is the first byte of a CS frame.
- oRX_VALID  out  1  RX FIFO not empty.
- iRX_READY  in  1  consumer accepts the head byte when iRX_READY and oRX_VALID are both high.
- iTX_DATA  in  8  next MISO byte.
- iTX_VALID  in  1  TX byte offered.
- oTX_READY  out  1  TX holding register empty.
- oFRAME_ACTIVE  out  1  synchronised CS asserted.
- oFRAME_END  out  1  one-cycle pulse on synchronised CS rising edge.
- oRX_OVERRUN  out  1  sticky; a byte was dropped because the FIFO was full.
- oTX_UNDERRUN  out  1  sticky; FILL_BYTE was sent because the holding register was empty.
- iCLR_FLAGS  in  1  clears both sticky flags.

Behaviour:
- **Reset values.** All outputs are 0 except oTX_READY=1. The FIFO is emptied, the bit counter is 0, and the state is IDLE.
- **Input synchronisation.** SCLK, MOSI and CSn each pass through a 2-FF synchroniser plus one history register.
  - Rise, fall and CS edges are detected in stage 3.
  - Pin-to-detect latency is 3 iCLK cycles.
- **Legal SCLK.** SPI mode 0, MSB first. The SCLK period must be at least 8 iCLK periods, with high and low phases each at least 3 iCLK.
- **State machine.**
  - IDLE → ACTIVE on the CSn falling edge. On entry:
    - clear the bit counter;
    - set the sof_pending flag;
    - load the MISO shift register from the holding register if it is full, otherwise load FILL_BYTE and set oTX_UNDERRUN;
    - drive MSB on oSPI_MISO in the same cycle oSPI_MISO_OE rises.
  - ACTIVE → IDLE on the CSn rising edge.
    - Pulse oFRAME_END.
    - Discard a partial byte (bit counter ≠ 0) silently and reset the counter to 0.
- **Receive (ACTIVE, SCLK rise).** Shift MOSI into the RX shift register and increment the counter modulo 8.
- **Byte completion.** When the counter wraps 7→0, write {sof_pending, byte} into the FIFO on the next cycle and clear sof_pending.
  - The FIFO is first-word fall-through: if it was empty, oRX_VALID rises in the cycle after the write.
- **FIFO full on write.** The byte is dropped, FIFO contents are unchanged, and oRX_OVERRUN is set.
- **Simultaneous pop and write when full.** The write succeeds; the pop frees the slot first.
- **Transmit (ACTIVE, SCLK fall).** Shift MISO left and present the next bit.
  - On the fall following the 8th rise, reload from the holding register, or use FILL_BYTE and set underrun.
  - The holding register empties on reload, and oTX_READY rises the next cycle.
- **TX handshake.** iTX_VALID && oTX_READY loads the holding register, and oTX_READY drops next cycle.
  - A load and a reload in the same cycle: the reload takes the old content and the new byte is stored. The register stays full.
- **Sticky flags.** They hold until iCLR_FLAGS. If set and clear happen in the same cycle, set wins.
- **FIFO pointers.** log2(RX_DEPTH)+1 bits; wrap naturally.
- **Reset mid-frame.** Return to IDLE with oSPI_MISO_OE=0 immediately.
  - The current frame is ignored until CSn is seen high, then low again.
  - A frame is never entered on reset release with CSn already low.

Test Plan:
- Reset, then a frame with CS low and bytes 0xA5, 0x3C, SCLK = iCLK/8, iRX_READY=1 → oRX_DATA sequence is 0xA5 (SOF=1) then 0x3C (SOF=0). oFRAME_END pulses once; no flags set.
- Preload iTX_DATA=0x81 and, during the byte, offer 0x7E; MISO over 3 bytes → 0x81, 0x7E, 0xFF. oTX_UNDERRUN is set only at the third byte load.
- Hold iRX_READY=0 and send RX_DEPTH+2 = 6 bytes 0x01–0x06 → FIFO holds 0x01–0x04, oRX_OVERRUN=1. Draining yields exactly those 4 bytes.
- Raise CS after 5 bits, then a new frame with 0x55 → the partial byte is not emitted; 0x55 arrives with SOF=1.
- Assert iRESET mid-byte with CS still low, release, continue clocking → no RX bytes and OE=0 until CS toggles high then low.
- Pulse iCLR_FLAGS in the same cycle as a new overrun → oRX_OVERRUN stays 1; a later clear with no event → 0.

Source files
------------

// File: rtl/nina_spi_byte_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nina_spi_byte_if
// Brief    : SPI-mode-0 slave front end for the NINA link. Oversamples the pins,
//            produces an RX byte FIFO and serialises TX bytes onto MISO.
// Revision : 1.0 - initial release
// ============================================================================
module nina_spi_byte_if #(
  parameter int         RX_DEPTH  = 4,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSPI_SCLK,
  input  logic       iSPI_MOSI,
  input  logic       iSPI_CSn,
  output logic       oSPI_MISO,
  output logic       oSPI_MISO_OE,
  output logic [7:0] oRX_DATA,
  output logic       oRX_SOF,
  output logic       oRX_VALID,
  input  logic       iRX_READY,
  input  logic [7:0] iTX_DATA,
  input  logic       iTX_VALID,
  output logic       oTX_READY,
  output logic       oFRAME_ACTIVE,
  output logic       oFRAME_END,
  output logic       oRX_OVERRUN,
  output logic       oTX_UNDERRUN,
  input  logic       iCLR_FLAGS
);

  localparam int c_AW = $clog2(RX_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t r_state, w_stateNext;

  logic [2:0]   r_sclkSync, r_mosiSync, r_csnSync;
  logic         w_sclkRise, w_sclkFall, w_csFall, w_csRise, w_mosi;
  logic         w_enter, w_exit, w_rxRise, w_txFall, w_reload, w_txLoad;
  logic [2:0]   r_bitCnt;
  logic [7:0]   r_rxShift, r_misoShift, r_txHold;
  logic         r_byteDone, r_sofPending, r_reloadDue, r_txFull;
  logic         r_underrun, r_overrun, r_frameEnd;
  logic [8:0]   r_mem [RX_DEPTH];
  logic [c_AW:0] r_wrPtr, r_rdPtr;
  logic         w_empty, w_full, w_pop, w_wr;
  logic [8:0]   w_head;

  // CS sync resets to "asserted" so a frame already in progress at reset
  // release is never entered; CS must be seen high first.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_sclkSync <= 3'b000;
      r_mosiSync <= 3'b000;
      r_csnSync  <= 3'b000;
    end else begin
      r_sclkSync <= {r_sclkSync[1:0], iSPI_SCLK};
      r_mosiSync <= {r_mosiSync[1:0], iSPI_MOSI};
      r_csnSync  <= {r_csnSync[1:0], iSPI_CSn};
    end
  end

  assign w_sclkRise = r_sclkSync[1] & ~r_sclkSync[2];
  assign w_sclkFall = ~r_sclkSync[1] & r_sclkSync[2];
  assign w_csFall   = ~r_csnSync[1] & r_csnSync[2];
  assign w_csRise   = r_csnSync[1] & ~r_csnSync[2];
  assign w_mosi     = r_mosiSync[2];

  always_ff @(posedge iCLK) begin
    if (iRESET) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE:    if (w_csFall) begin w_stateNext = ACTIVE; w_enter = 1'b1; end
      ACTIVE:  if (w_csRise) begin w_stateNext = IDLE;   w_exit  = 1'b1; end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_rxRise = (r_state == ACTIVE) & w_sclkRise;
  assign w_txFall = (r_state == ACTIVE) & w_sclkFall;
  assign w_reload = w_enter | (w_txFall & r_reloadDue);
  assign w_txLoad = iTX_VALID & ~r_txFull;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_bitCnt     <= 3'd0;
      r_rxShift    <= 8'h00;
      r_byteDone   <= 1'b0;
      r_sofPending <= 1'b0;
      r_reloadDue  <= 1'b0;
      r_misoShift  <= 8'h00;
      r_txHold     <= 8'h00;
      r_txFull     <= 1'b0;
      r_underrun   <= 1'b0;
      r_frameEnd   <= 1'b0;
    end else begin
      r_byteDone <= 1'b0;
      r_frameEnd <= w_exit;
      if (r_byteDone) r_sofPending <= 1'b0;
      if (w_enter) begin
        r_bitCnt     <= 3'd0;
        r_sofPending <= 1'b1;
        r_reloadDue  <= 1'b0;
      end else if (w_exit) begin
        r_bitCnt    <= 3'd0;
        r_reloadDue <= 1'b0;
      end else if (w_rxRise) begin
        r_rxShift <= {r_rxShift[6:0], w_mosi};
        r_bitCnt  <= r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) begin
          r_byteDone  <= 1'b1;
          r_reloadDue <= 1'b1;
        end
      end
      if (w_reload) begin
        r_misoShift <= r_txFull ? r_txHold : FILL_BYTE;
        if (!w_enter) r_reloadDue <= 1'b0;
      end else if (w_txFall) begin
        r_misoShift <= {r_misoShift[6:0], 1'b0};
      end
      // A load wins over a same-cycle reload: the reload consumed the old content.
      if (w_txLoad) begin
        r_txHold <= iTX_DATA;
        r_txFull <= 1'b1;
      end else if (w_reload) begin
        r_txFull <= 1'b0;
      end
      r_underrun <= (w_reload & ~r_txFull) | (r_underrun & ~iCLR_FLAGS);
    end
  end

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                   (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  assign w_pop   = ~w_empty & iRX_READY;
  assign w_wr    = r_byteDone & (~w_full | w_pop);
  assign w_head  = r_mem[r_rdPtr[c_AW-1:0]];

  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wrPtr[c_AW-1:0]] <= {r_sofPending, r_rxShift};
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wrPtr <= r_wrPtr + {{c_AW{1'b0}}, 1'b1};
      if (w_pop) r_rdPtr <= r_rdPtr + {{c_AW{1'b0}}, 1'b1};
      r_overrun <= (r_byteDone & w_full & ~w_pop) | (r_overrun & ~iCLR_FLAGS);
    end
  end

  assign oRX_VALID     = ~w_empty;
  assign oRX_DATA      = w_empty ? 8'h00 : w_head[7:0];
  assign oRX_SOF       = ~w_empty & w_head[8];
  assign oSPI_MISO     = r_misoShift[7];
  assign oSPI_MISO_OE  = (r_state == ACTIVE);
  assign oFRAME_ACTIVE = (r_state == ACTIVE);
  assign oFRAME_END    = r_frameEnd;
  assign oTX_READY     = ~r_txFull;
  assign oRX_OVERRUN   = r_overrun;
  assign oTX_UNDERRUN  = r_underrun;

endmodule
`default_nettype wire
